// File: rtl/demux1_4.sv
// One-to-four registered demultiplexer with per-channel valid/ready handshakes,
// explicit or round-robin (TDM) routing, synchronous flush and async reset.
module demux1_4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             auto_sel,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    input  logic [3:0]       y_ready,
    output logic [1:0]       rr_ptr
);

    logic [WIDTH-1:0] data_r [4];
    logic [3:0]       valid_r;
    logic [1:0]       rr_ptr_r;
    logic [1:0]       eff_sel_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [3:0]       load_s;

    // Target channel selection, upstream handshake and one-hot load strobe.
    always_comb begin
        eff_sel_s  = sel;
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        load_s     = 4'b0000;
        if (auto_sel) begin
            eff_sel_s = rr_ptr_r;
        end else begin
            eff_sel_s = sel;
        end
        // A stalled target blocks the whole stream; other channels are never skipped to.
        in_ready_s = ~flush & (~valid_r[eff_sel_s] | y_ready[eff_sel_s]);
        accept_s   = in_valid & in_ready_s;
        if (accept_s) begin
            load_s[eff_sel_s] = 1'b1;
        end else begin
            load_s = 4'b0000;
        end
    end

    // Channel data registers; contents survive drain and flush, only valid qualifies them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                data_r[k] <= {WIDTH{1'b0}};
            end
        end else if (!flush) begin
            for (int k = 0; k < 4; k++) begin
                if (load_s[k]) begin
                    data_r[k] <= in_data;
                end
            end
        end
    end

    // Channel valid flags: reload wins over drain so a pass-through keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 4'b0000;
        end else if (flush) begin
            valid_r <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load_s[k]) begin
                    valid_r[k] <= 1'b1;
                end else if (y_ready[k]) begin
                    valid_r[k] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer advances only on accepts made in auto mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= 2'd0;
        end else if (flush) begin
            rr_ptr_r <= 2'd0;
        end else if (auto_sel && accept_s) begin
            rr_ptr_r <= rr_ptr_r + 2'd1;
        end
    end

    assign in_ready = in_ready_s;
    assign y0       = data_r[0];
    assign y1       = data_r[1];
    assign y2       = data_r[2];
    assign y3       = data_r[3];
    assign y_valid  = valid_r;
    assign rr_ptr   = rr_ptr_r;

endmodule

// File: tb/tb_demux1_4.sv
// Self-checking bench for demux1_4: directed scenarios plus randomized traffic
// compared against a channel-occupancy model kept in the bench.
module tb_demux1_4;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       auto_sel;
    logic [1:0] sel;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] y0, y1, y2, y3;
    logic [3:0] y_valid;
    logic [3:0] y_ready;
    logic [1:0] rr_ptr;

    int checks   = 0;
    int failures = 0;

    // Model: what each channel holds, whether it is occupied, and the TDM slot.
    logic [7:0] md [4];
    logic [3:0] mv;
    logic [1:0] mp;
    logic [7:0] yo [4];

    assign yo[0] = y0;
    assign yo[1] = y1;
    assign yo[2] = y2;
    assign yo[3] = y3;

    always #5 clk = ~clk;

    demux1_4 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .auto_sel(auto_sel), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .y_valid(y_valid), .y_ready(y_ready), .rr_ptr(rr_ptr)
    );

    function automatic int target();
        return auto_sel ? int'(mp) : int'(sel);
    endfunction

    function automatic logic exp_ready();
        return !flush && (!mv[target()] || y_ready[target()]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) md[k] = 8'h00;
        mv = 4'b0000;
        mp = 2'd0;
    endtask

    task automatic drive(input logic f, input logic a, input logic [1:0] s,
                         input logic iv, input logic [7:0] d, input logic [3:0] yr);
        flush = f; auto_sel = a; sel = s; in_valid = iv; in_data = d; y_ready = yr;
        #1;
    endtask

    // Advance one clock edge and apply the same transfer to the model; returns at negedge.
    task automatic tick();
        int  t;
        logic acc;
        t   = target();
        acc = in_valid && exp_ready();
        @(posedge clk);
        if (flush) begin
            mv = 4'b0000;
            mp = 2'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (acc && k == t) begin
                    md[k] = in_data;
                    mv[k] = 1'b1;
                end else if (mv[k] && y_ready[k]) begin
                    mv[k] = 1'b0;
                end
            end
            if (acc && auto_sel) mp = mp + 2'd1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        model_reset();
        @(negedge clk);
        checks++; if (y_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=%b", y_valid, 4'b0000); end
        checks++; if (rr_ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", rr_ptr); end
        checks++; if ({y0, y1, y2, y3} !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {y0, y1, y2, y3}); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_explicit();
        drive(1'b0, 1'b0, 2'd2, 1'b1, 8'hA5, 4'b1111);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL explicit_ready got=%b exp=1", in_ready); end
        tick();
        checks++; if (y2 !== 8'hA5) begin failures++; $display("FAIL explicit_y2 got=%h exp=a5", y2); end
        checks++; if (y_valid !== 4'b0100) begin failures++; $display("FAIL explicit_valid got=%b exp=0100", y_valid); end
        checks++; if ({y0, y1, y3} !== 24'h0) begin failures++; $display("FAIL explicit_others got=%h exp=0", {y0, y1, y3}); end
        drive(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        tick();
    endtask

    task automatic test_rr_wrap();
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            d = 8'h10 + 8'(i);
            drive(1'b0, 1'b1, 2'd0, 1'b1, d, 4'b1111);
            checks++; if (rr_ptr !== 2'(i % 4)) begin failures++; $display("FAIL rr_ptr_seq got=%0d exp=%0d", rr_ptr, i % 4); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rr_ready got=%b exp=1", in_ready); end
            tick();
        end
        checks++; if (rr_ptr !== 2'd1) begin failures++; $display("FAIL rr_ptr_end got=%0d exp=1", rr_ptr); end
        checks++; if ({y0, y1, y2, y3} !== 32'h14111213) begin failures++; $display("FAIL rr_data got=%h exp=14111213", {y0, y1, y2, y3}); end
        checks++; if (y_valid !== 4'b0001) begin failures++; $display("FAIL rr_valid got=%b exp=0001", y_valid); end
        drive(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b0, 1'b0, 2'd1, 1'b1, 8'h55, 4'b1101);
        tick();
        drive(1'b0, 1'b0, 2'd1, 1'b1, 8'h66, 4'b1101);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall got=%b exp=0", in_ready); end
        tick();
        checks++; if (y1 !== 8'h55 || y_valid[1] !== 1'b1) begin failures++; $display("FAIL bp_hold got=%h/%b exp=55/1", y1, y_valid[1]); end
        drive(1'b0, 1'b0, 2'd1, 1'b1, 8'h66, 4'b1111);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", in_ready); end
        tick();
        checks++; if (y1 !== 8'h66 || y_valid[1] !== 1'b1) begin failures++; $display("FAIL bp_pass got=%h/%b exp=66/1", y1, y_valid[1]); end
        drive(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        tick();
        checks++; if (y_valid !== 4'b0000) begin failures++; $display("FAIL bp_drain got=%b exp=0000", y_valid); end
    endtask

    task automatic test_rr_stall();
        drive(1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 4'b1111);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'd0, 1'b1, 8'h20 + 8'(i), 4'b1110);
            tick();
        end
        drive(1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 4'b1110);
        tick();
        checks++; if (y_valid !== 4'b0001 || rr_ptr !== 2'd0) begin failures++; $display("FAIL stall_setup got=%b/%0d exp=0001/0", y_valid, rr_ptr); end
        drive(1'b0, 1'b1, 2'd0, 1'b1, 8'h30, 4'b1110);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
        tick();
        checks++; if (y0 !== 8'h20 || rr_ptr !== 2'd0) begin failures++; $display("FAIL stall_hold got=%h/%0d exp=20/0", y0, rr_ptr); end
        drive(1'b0, 1'b1, 2'd0, 1'b1, 8'h30, 4'b1111);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_resume got=%b exp=1", in_ready); end
        tick();
        checks++; if (y0 !== 8'h30 || rr_ptr !== 2'd1) begin failures++; $display("FAIL stall_accept got=%h/%0d exp=30/1", y0, rr_ptr); end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 4'b1111);
        tick();
        drive(1'b0, 1'b1, 2'd0, 1'b1, 8'h40, 4'b0000);
        tick();
        drive(1'b0, 1'b1, 2'd0, 1'b1, 8'h41, 4'b0000);
        tick();
        drive(1'b0, 1'b0, 2'd3, 1'b1, 8'h43, 4'b0010);
        tick();
        checks++; if (y_valid !== 4'b1001 || rr_ptr !== 2'd2) begin failures++; $display("FAIL flush_setup got=%b/%0d exp=1001/2", y_valid, rr_ptr); end
        drive(1'b1, 1'b1, 2'd0, 1'b1, 8'h99, 4'b0000);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        tick();
        checks++; if (y_valid !== 4'b0000 || rr_ptr !== 2'd0) begin failures++; $display("FAIL flush_clear got=%b/%0d exp=0000/0", y_valid, rr_ptr); end
        checks++; if (y0 !== 8'h40 || y3 !== 8'h43) begin failures++; $display("FAIL flush_data got=%h/%h exp=40/43", y0, y3); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 2'(i), 1'b1, 8'hC0 + 8'(i), 4'b0000);
            tick();
        end
        checks++; if (y_valid !== 4'b1111) begin failures++; $display("FAIL areset_full got=%b exp=1111", y_valid); end
        drive(1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 4'b0000);
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (y_valid !== 4'b0000 || rr_ptr !== 2'd0) begin failures++; $display("FAIL areset_clear got=%b/%0d exp=0000/0", y_valid, rr_ptr); end
        checks++; if ({y0, y1, y2, y3} !== 32'h0 || in_ready !== 1'b1) begin failures++; $display("FAIL areset_data got=%h/%b exp=0/1", {y0, y1, y2, y3}, in_ready); end
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b1, 2'd2, 1'b1, 8'h77, 4'b0000);
        tick();
        checks++; if (y0 !== 8'h77 || y_valid !== 4'b0001 || rr_ptr !== 2'd1) begin failures++; $display("FAIL areset_first got=%h/%b/%0d exp=77/0001/1", y0, y_valid, rr_ptr); end
    endtask

    task automatic test_random();
        int nbad;
        nbad = 0;
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 19) == 0), (c >= 200) ? 1'b1 : 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                  8'($urandom), 4'($urandom));
            checks++; if (in_ready !== exp_ready()) begin failures++; nbad++; if (nbad < 10) $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_ready()); end
            tick();
            checks++; if (y_valid !== mv || rr_ptr !== mp) begin failures++; nbad++; if (nbad < 10) $display("FAIL rand_state cyc=%0d got=%b/%0d exp=%b/%0d", c, y_valid, rr_ptr, mv, mp); end
            for (int k = 0; k < 4; k++) begin
                checks++; if (yo[k] !== md[k]) begin failures++; nbad++; if (nbad < 10) $display("FAIL rand_data cyc=%0d ch=%0d got=%h exp=%h", c, k, yo[k], md[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_explicit();
        test_rr_wrap();
        test_backpressure();
        test_rr_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux1_4.md
DEMUX1_4 -- requirements
Module: demux1_4

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data width of every channel.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port flush, input, 1 bit, synchronous clear of buffered data and round-robin pointer.
REQ-005 SHALL have port auto_sel, input, 1 bit; 1 = round-robin routing (TDM), 0 = explicit routing by sel.
REQ-006 SHALL have port sel, input, 2 bits, destination channel when auto_sel=0.
REQ-007 SHALL have port in_valid, input, 1 bit, upstream word present.
REQ-008 SHALL have port in_data, input, WIDTH bits, upstream word.
REQ-009 SHALL have port in_ready, output, 1 bit, block accepts the word this cycle.
REQ-010 SHALL have ports y0, y1, y2, y3, outputs, WIDTH bits each, channel data registers.
REQ-011 SHALL have port y_valid, output, 4 bits; bit k qualifies yk.
REQ-012 SHALL have port y_ready, input, 4 bits; bit k = channel k consumer accepts.
REQ-013 SHALL have port rr_ptr, output, 2 bits, current round-robin channel.

Function
REQ-014 SHALL define eff_sel = rr_ptr when auto_sel=1, else sel, evaluated combinationally each cycle.
REQ-015 SHALL drive in_ready = ~flush & (~y_valid[eff_sel] | y_ready[eff_sel]); combinational, no dependence on in_valid.
REQ-016 SHALL define accept = in_valid & in_ready; only channel eff_sel is written on accept.
REQ-017 SHALL, on accept, load y<eff_sel> with in_data and set y_valid[eff_sel] at the next edge (latency 1 cycle).
REQ-018 SHALL clear y_valid[k] at the edge where y_valid[k] & y_ready[k] and channel k is not reloaded that cycle.
REQ-019 SHALL, on simultaneous drain and reload of the same channel, keep y_valid[k]=1 and load the new word (full-throughput pass-through).
REQ-020 SHALL hold yk stable while y_valid[k]=1 and y_ready[k]=0; an occupied, stalled channel never is overwritten.
REQ-021 SHALL leave yk at its last value after drain; only y_valid qualifies data.
REQ-022 SHALL, in auto_sel=1, increment rr_ptr modulo 4 on each accept (3 wraps to 0); no increment without accept.
REQ-023 SHALL hold rr_ptr unchanged while auto_sel=0; switching modes does not reset it.
REQ-024 SHALL stall all of the stream (in_ready=0) when the round-robin target is full, even if other channels are empty; no skipping.
REQ-025 SHALL treat channels independently: drains on any channels proceed the same cycle as an accept on another.
REQ-026 SHALL, on flush=1, clear all y_valid bits and rr_ptr to 0 at the next edge, accept nothing that cycle, and keep yk data unchanged; flush overrides drains and loads.

Reset
REQ-027 SHALL, while rst=1, immediately force y_valid=4'b0000, rr_ptr=0, y0..y3=0, hence in_ready=1 if flush=0.
REQ-028 SHALL discard any word in flight when reset asserts mid-operation; first accept after release lands in channel 0 in auto mode.
REQ-029 SHALL resume normal operation at the first rising clk edge after rst deasserts.

Verification
REQ-030 Explicit routing: auto_sel=0, y_ready=4'b1111, send sel=2/data 0xA5 -> next cycle y2=0xA5, y_valid=4'b0100, other channels unchanged.
REQ-031 Round-robin wrap: auto_sel=1, y_ready=1111, send 0x10,0x11,0x12,0x13,0x14 back-to-back -> y0..y3 get 0x10..0x13, then y0=0x14, rr_ptr sequence 0,1,2,3,0,1, in_ready held 1.
REQ-032 Backpressure: y_ready[1]=0, two sel=1 words 0x55 then 0x66 -> 0x55 held in y1, in_ready=0 for second word until y_ready[1]=1; same edge accepts 0x66, y_valid[1] stays 1.
REQ-033 Round-robin stall: auto_sel=1, channel 0 full with y_ready[0]=0, rr_ptr=0 -> in_ready=0 with channels 1-3 empty; release y_ready[0] -> accept resumes into channel 0.
REQ-034 Flush: channels 0 and 3 valid, rr_ptr=2, flush=1 with in_valid=1 -> in_ready=0, next cycle y_valid=0000, rr_ptr=0, y0/y3 data unchanged.
REQ-035 Async reset mid-stream: rst pulsed between clock edges with y_valid=1111 -> outputs clear immediately without a clock edge, rr_ptr=0.
